// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: the arbiter state enum, the fixed Wishbone address width, and a
// one-hot decode helper sized for the largest supported master count.
package wb_arb_pkg;

    localparam int ADR_WIDTH = 32;
    localparam int MAX_MST   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TOUT = 2'd2
    } arb_state_e;

    // Decode a master index into a MAX_MST-wide one-hot vector; callers
    // truncate to their own master count.
    function automatic logic [MAX_MST-1:0] onehot(input logic [2:0] idx);
        logic [MAX_MST-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin priority encoder: picks the first requester after 'last'.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is committed.
//
// Ports: req (per-master request), last (index of previous winner),
//        win_oh / win_idx (winner as one-hot and index), win_vld (any request).
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int IW      = $clog2(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_MST-1:0] win_oh,
    output logic [IW-1:0]      win_idx,
    output logic               win_vld
);

    logic [NUM_MST-1:0] hi_mask;
    logic [NUM_MST-1:0] req_hi;
    logic [NUM_MST-1:0] cand;

    // Requests strictly above 'last' take precedence; if there are none the
    // search wraps and the lowest-numbered requester wins.
    always_comb begin
        hi_mask = '0;
        for (int b = 0; b < NUM_MST; b++) begin
            hi_mask[b] = (b > int'(last));
        end
        req_hi = req & hi_mask;
        cand   = (req_hi != '0) ? req_hi : req;

        // Descending scan so the lowest set bit is the final assignment.
        win_idx = '0;
        for (int b = NUM_MST - 1; b >= 0; b--) begin
            if (cand[b]) begin
                win_idx = IW'(b);
            end
        end

        win_vld = (req != '0);
        win_oh  = win_vld ? NUM_MST'(onehot(3'(win_idx))) : '0;
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MST masters, with response watchdog.
// Latency: grant 1 cycle after m_cyc is sampled; ack/err/data paths are combinational in BUSY.
// Backpressure: the owner keeps the bus while m_cyc stays high; others wait, slave stalls via late ack.
//
// Ports: clk/rst_n; m_* per-master Wishbone request side (cyc, stb, we, adr, sel, dat_w in;
//        dat_r broadcast, ack/err routed to owner); gnt one-hot registered grant;
//        s_* single Wishbone slave side.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MST   = 2,
    parameter int BUS_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_MST-1:0]                    m_cyc,
    input  logic [NUM_MST-1:0]                    m_stb,
    input  logic [NUM_MST-1:0]                    m_we,
    input  logic [NUM_MST-1:0][ADR_WIDTH-1:0]     m_adr,
    input  logic [NUM_MST-1:0][BUS_WIDTH/8-1:0]   m_sel,
    input  logic [NUM_MST-1:0][BUS_WIDTH-1:0]     m_dat_w,
    output logic [BUS_WIDTH-1:0]                  m_dat_r,
    output logic [NUM_MST-1:0]                    m_ack,
    output logic [NUM_MST-1:0]                    m_err,
    output logic [NUM_MST-1:0]                    gnt,
    output logic                                  s_cyc,
    output logic                                  s_stb,
    output logic                                  s_we,
    output logic [ADR_WIDTH-1:0]                  s_adr,
    output logic [BUS_WIDTH/8-1:0]                s_sel,
    output logic [BUS_WIDTH-1:0]                  s_dat_w,
    input  logic [BUS_WIDTH-1:0]                  s_dat_r,
    input  logic                                  s_ack,
    input  logic                                  s_err
);

    localparam int IW = $clog2(NUM_MST);
    // A zero-width counter is illegal, so a disabled watchdog keeps one dead bit.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT);
    localparam logic          WDOG_EN = (TIMEOUT > 0);

    arb_state_e          state_q, state_d;
    logic [NUM_MST-1:0]  gnt_q,   gnt_d;
    logic [IW-1:0]       last_q,  last_d;
    logic [CW-1:0]       cnt_q,   cnt_d;

    logic [NUM_MST-1:0]  pick_oh;
    logic [IW-1:0]       pick_idx;
    logic                pick_vld;
    logic                busy;
    logic                tout;
    logic                unanswered;

    wb_rr_pick #(
        .NUM_MST (NUM_MST),
        .IW      (IW)
    ) u_pick (
        .req     (m_cyc),
        .last    (last_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

    assign busy    = (state_q == BUSY);
    assign tout    = (state_q == TOUT);
    assign gnt     = gnt_q;
    assign m_dat_r = s_dat_r;

    // While BUSY, last_q is the owner's index, so it doubles as the mux select.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_sel   = '0;
        s_dat_w = '0;
        if (busy) begin
            s_cyc   = m_cyc[last_q];
            s_stb   = m_stb[last_q];
            s_we    = m_we[last_q];
            s_adr   = m_adr[last_q];
            s_sel   = m_sel[last_q];
            s_dat_w = m_dat_w[last_q];
        end
    end

    // Responses reach only the owner; the TOUT cycle fabricates an err.
    always_comb begin
        m_ack = '0;
        m_err = '0;
        if (busy) begin
            m_ack = gnt_q & {NUM_MST{s_ack}};
            m_err = gnt_q & {NUM_MST{s_err}};
        end else if (tout) begin
            m_err = gnt_q;
        end
    end

    assign unanswered = busy & s_stb & ~s_ack & ~s_err;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick_oh;
                    last_d  = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!m_cyc[last_q]) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (WDOG_EN && unanswered) begin
                    // The counter stops at the limit; the state change clears it.
                    if (cnt_q == CNT_LIM) begin
                        state_d = TOUT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            TOUT: begin
                if (m_cyc[last_q]) begin
                    state_d = BUSY;
                end else begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NUM_MST - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Round-robin arbiter that shares one Wishbone slave port among NUM_MST masters in the testbench/target environment. It sits between the RMAP target's bus masters and the single memory-side Wishbone slave, sequencing whole bus cycles (cyc-framed) and isolating the masters from a hung slave via a response-timeout watchdog.

## Interface
- NUM_MST, 2, number of masters (2..8)
- BUS_WIDTH, 32, data width; sel width BUS_WIDTH/8
- TIMEOUT, 255, cycles of unanswered stb before error; 0 disables watchdog

- clk  in  1  bus clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m_cyc  in  NUM_MST  per-master cycle request
- m_stb  in  NUM_MST  per-master strobe
- m_we  in  NUM_MST  per-master write enable
- m_adr  in  NUM_MST x 32  per-master address
- m_sel  in  NUM_MST x BUS_WIDTH/8  per-master byte select
- m_dat_w  in  NUM_MST x BUS_WIDTH  per-master write data
- m_dat_r  out  BUS_WIDTH  read data, s_dat_r broadcast to all masters
- m_ack  out  NUM_MST  ack routed to granted master only
- m_err  out  NUM_MST  err routed to granted master only (slave err or timeout)
- gnt  out  NUM_MST  registered one-hot grant
- s_cyc, s_stb, s_we  out  1 each  to slave
- s_adr  out  32;  s_sel  out  BUS_WIDTH/8;  s_dat_w  out  BUS_WIDTH  to slave
- s_dat_r  in  BUS_WIDTH;  s_ack, s_err  in  1 each  from slave

## Operation
- States: IDLE, BUSY, TOUT.
- IDLE: gnt=0, slave outputs 0. If any m_cyc=1, pick winner by round-robin starting at index (last+1) mod NUM_MST; register gnt, update last, go BUSY.
- BUSY: slave side combinationally muxed from granted master (cyc, stb, we, adr, sel, dat_w); s_ack/s_err routed to m_ack/m_err[g]. Grant held while m_cyc[g]=1 regardless of other requests (multi-beat/locked cycles allowed). m_cyc[g]=0 sampled -> gnt cleared, IDLE.
- Watchdog (TIMEOUT>0): counter increments each cycle in BUSY with s_stb=1 and s_ack=s_err=0; clears on ack, err, stb=0, or leaving BUSY. Count reaching TIMEOUT -> TOUT.
- TOUT: one cycle; s_cyc=s_stb=0, m_err[g]=1, m_ack=0; counter cleared; return to BUSY if m_cyc[g]=1 else IDLE.
- Non-granted masters see m_ack=m_err=0 always.
- Simultaneous s_ack and s_err: both passed through; master treats err as dominant.

## Timing
- Reset (async assert, sync-released by rst_n deassert at clock edge): state IDLE, gnt=0, last=NUM_MST-1 (master 0 first priority), counter 0; all s_* outputs 0, m_ack=m_err=0, m_dat_r follows s_dat_r.
- Grant latency: m_cyc rising sampled at edge k -> gnt and s_cyc high after edge k, i.e. slave sees request 1 cycle after master.
- Release: m_cyc[g] low sampled at edge k -> gnt=0 after k; next grant after edge k+1 earliest (one idle cycle between owners).
- Ack/err path: combinational, zero added latency in BUSY.
- Timeout: m_err[g] asserted exactly TIMEOUT+1 cycles after stb first seen unanswered in BUSY.
- Reset mid-transaction: immediate drop of s_cyc/s_stb and gnt; no ack/err generated.
- Master dropping m_cyc mid-beat: allowed; slave sees cyc drop same cycle (combinational mux), grant released next edge.

## Structure
- Package wb_arb_pkg: state enum typedef (IDLE, BUSY, TOUT), ADR_WIDTH=32 constant, one-hot helper function.
- Sub-module wb_rr_pick: combinational round-robin priority encoder (req, last -> one-hot winner, index).
- Counter width $clog2(TIMEOUT+1); saturating, never wraps.

## Test plan
- Single master 0 write adr 0x10, dat 0xDEADBEEF, slave ack after 2 cycles -> s_cyc 1 cycle after m_cyc, m_ack[0]=1 once, m_ack[1]=0.
- Both masters request same cycle after reset -> gnt=01 first, then 10 after master 0 drops cyc plus one idle cycle; repeat -> alternates 01/10.
- Master 1 holds cyc for 4 beats while master 0 requests -> gnt stays 10 for all 4 acks, then 01.
- Slave never acks, TIMEOUT=8 -> m_err[g]=1 for exactly one cycle 9 cycles after stb, s_stb=0 that cycle.
- Slave returns s_err on read -> m_err[g]=1, m_dat_r equals s_dat_r, grant retained.
- rst_n asserted during BUSY with stb=1 -> gnt=0, s_cyc=0 asynchronously; after release master 0 wins first.
